tick_down_counter: RTL
======================

Name: tick_down_counter

Overview:
- Loadable down-counter/countdown timer with a built-in synchronous prescaler. It is the decrementing counterpart to the board's ripple up-counter/clock-divider chain.
- A single free-running clk drives all logic. There is no derived or ripple clock; the prescaler produces a one-cycle tick enable.
- Drives LED/segment logic and signals expiry to control logic.

Parameters:
WIDTH, 4, bit width of count value
PRESCALE_BITS, 20, prescaler width; one tick every 2^PRESCALE_BITS clk cycles

Ports:
clk  input  1  system clock; all state updates on falling edge of clk
reset  input  1  reset, asynchronous, active-high
load  input  1  load load_val into count and reload register
load_val  input  WIDTH  value to load
start  input  1  begin/restart countdown
pause  input  1  level; freezes countdown while high
stop  input  1  abort; return to IDLE, count cleared
count  output  WIDTH  current count value
state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3
busy  output  1  high in RUN or PAUSED
done  output  1  high while in DONE
zero_pulse  output  1  one-cycle pulse when count reaches zero

Behaviour:
- Reset (async, immediate):
  - state=IDLE; count=0; reload register=0; prescaler=0.
  - busy=0, done=0, zero_pulse=0.
- Control priority each edge: stop > load > start > pause.
- Prescaler:
  - Counts only in RUN; held in PAUSED; cleared in IDLE/DONE and on every RUN entry.
  - Tick asserts on the clk cycle where prescaler = all-ones, then the prescaler wraps to 0.
  - First decrement therefore occurs exactly 2^PRESCALE_BITS edges after the start edge.
- IDLE:
  - load: count<=load_val, reload<=load_val.
  - start with effective value !=0 → RUN. The effective value is load_val if load is asserted on the same edge, else count.
  - start with effective value 0: ignored, stays IDLE.
- RUN:
  - On tick: count<=count-1.
  - If count was 1: count<=0, zero_pulse=1 for the following cycle, state→DONE.
  - pause high (including on a tick edge): → PAUSED, no decrement that edge.
  - load in RUN: ignored. start in RUN: prescaler cleared, count<=reload (restart).
- PAUSED:
  - pause low → RUN, prescaler resumes from held value.
  - start: restart as in RUN.
  - load ignored.
- DONE:
  - done=1, count=0.
  - start with reload!=0 → count<=reload, RUN.
  - load → count/reload updated, → IDLE.
- stop in any state: → IDLE, count=0, reload unchanged, prescaler cleared.
- Reset mid-RUN: all state lost; no zero_pulse generated.
- count never wraps below 0; arithmetic is modulo 2^WIDTH unsigned, but decrement from 0 is unreachable.
- Outputs:
  - Registered.
  - busy/done decode from registered state.
  - zero_pulse is a registered single-cycle pulse.

Optional Feature:
- Macro: TICK_DOWN_AUTO_RELOAD_EN.
- Defined (auto-reload):
  - On a tick where count==1, count<=reload instead of 0.
  - zero_pulse asserts one cycle; state stays RUN; DONE is never entered from RUN.
  - Prescaler continues without clearing, so periods are exactly reload*2^PRESCALE_BITS cycles.
- Undefined: one-shot behaviour as specified above.
- stop/pause/load priority unchanged in both builds.

Test Plan (PRESCALE_BITS=2, WIDTH=4):
- Reset release, load=1 load_val=3, then start: count 3→2→1→0 at edges 4, 8, 12 after start; zero_pulse high 1 cycle after edge 12; state=DONE, done=1, busy=0.
- Same-edge load=1 load_val=5 with start=1 in IDLE: state=RUN, count=5. start with count=0 and load=0: state stays IDLE.
- RUN at count=4 with prescaler=2, pause held 10 cycles: count stays 4, state=PAUSED. Release: next decrement 2 cycles later (count=3).
- stop asserted in RUN at count=2: state=IDLE, count=0, busy=0, no zero_pulse. Then start in DONE after a full run of 3: count reloads 3, RUN.
- Async reset asserted mid-cycle in RUN at count=6: count=0, state=IDLE, all flags 0 immediately without a clk edge.
- With TICK_DOWN_AUTO_RELOAD_EN, load 2 and start: count 2,1,2,1,…; zero_pulse every 8 cycles; done never 1.

Source files
------------

// File: rtl/tick_down_counter.sv
// -----------------------------------------------------------------------------
// tick_down_counter
//
// Loadable countdown timer with a built-in synchronous prescaler. Every flop
// is clocked by one free-running clock. The prescaler does not make a derived
// clock. It produces a one-cycle tick enable that gates the decrement. All
// state updates on the FALLING edge of clk.
//
// Optional build macro:
//   TICK_DOWN_AUTO_RELOAD_EN
//     Undefined: one-shot. Reaching zero parks the block in DONE.
//     Defined:   auto-reload. The count reloads on expiry and stays in RUN.
//
// Parameters:
//   WIDTH          count width
//   PRESCALE_BITS  prescaler width; one tick every 2^PRESCALE_BITS clk cycles
//
// Ports:
//   clk         in   system clock (state updates on falling edge)
//   reset       in   asynchronous, active-high reset
//   load        in   load load_val into count and reload register
//   load_val    in   [WIDTH-1:0] value to load
//   start       in   begin / restart the countdown
//   pause       in   level; freezes the countdown while high
//   stop        in   abort; return to IDLE with count cleared
//   count       out  [WIDTH-1:0] current count
//   state       out  [1:0] IDLE=0, RUN=1, PAUSED=2, DONE=3
//   busy        out  high in RUN or PAUSED
//   done        out  high while in DONE
//   zero_pulse  out  one-cycle pulse when the count expires
//
// Control priority on each edge: stop > load > start > pause.
// -----------------------------------------------------------------------------
module tick_down_counter #(
    parameter int WIDTH         = 4,
    parameter int PRESCALE_BITS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             zero_pulse
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [WIDTH-1:0]         r_count;
    logic [WIDTH-1:0]         r_reload;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic                     r_zero_pulse;

    // Next-state values
    logic [1:0]               w_state_next;
    logic [WIDTH-1:0]         w_count_next;
    logic [WIDTH-1:0]         w_reload_next;
    logic [PRESCALE_BITS-1:0] w_prescale_next;
    logic                     w_zero_pulse_next;

    // -------------------------------------------------------------------------
    // Helper decodes
    // -------------------------------------------------------------------------
    logic                     w_tick;
    logic                     w_count_is_one;
    logic [WIDTH-1:0]         w_start_val;
    logic                     w_start_ok;
    logic                     w_reload_nonzero;

    // The tick fires on the cycle where the prescaler is all-ones. The
    // prescaler then wraps to zero on that same edge. It only counts in RUN,
    // so the tick is qualified by the state.
    assign w_tick           = (r_state == S_RUN) && (&r_prescale);
    assign w_count_is_one   = (r_count == WIDTH'(1));
    assign w_reload_nonzero = (r_reload != '0);

    // From IDLE, a start uses the value being loaded on the same edge, if any.
    // Otherwise it uses the count already held. A zero start value is ignored.
    assign w_start_val      = load ? load_val : r_count;
    assign w_start_ok       = (w_start_val != '0);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_reload_next     = r_reload;
        w_prescale_next   = r_prescale;
        w_zero_pulse_next = 1'b0;

        if (stop) begin
            // Abort from anywhere. The reload value is kept so a later start
            // from DONE still has something to reload.
            w_state_next    = S_IDLE;
            w_count_next    = '0;
            w_prescale_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_prescale_next = '0;
                    if (load) begin
                        w_count_next  = load_val;
                        w_reload_next = load_val;
                    end
                    if (start && w_start_ok) begin
                        // The prescaler is already zero here. This is the
                        // RUN entry point.
                        w_state_next = S_RUN;
                    end
                end

                S_RUN: begin
                    // load has no effect while counting.
                    if (start) begin
                        // Restart: fresh prescaler period, count from reload.
                        w_count_next    = r_reload;
                        w_prescale_next = '0;
                    end else if (pause) begin
                        // Freeze now. The prescaler is held, so resuming
                        // later finishes the interrupted period.
                        w_state_next = S_PAUSED;
                    end else begin
                        w_prescale_next = r_prescale + PRESCALE_BITS'(1);
                        if (w_tick) begin
                            if (w_count_is_one) begin
                                w_zero_pulse_next = 1'b1;
`ifdef TICK_DOWN_AUTO_RELOAD_EN
                                // Keep running. The prescaler keeps wrapping
                                // freely, so every period is exactly
                                // reload * 2^PRESCALE_BITS cycles.
                                w_count_next = r_reload;
`else
                                w_count_next    = '0;
                                w_state_next    = S_DONE;
                                w_prescale_next = '0;
`endif
                            end else begin
                                w_count_next = r_count - WIDTH'(1);
                            end
                        end
                    end
                end

                S_PAUSED: begin
                    // load has no effect while paused.
                    if (start) begin
                        w_state_next    = S_RUN;
                        w_count_next    = r_reload;
                        w_prescale_next = '0;
                    end else if (!pause) begin
                        // Resume. The prescaler keeps its held value and
                        // starts advancing on the next edge in RUN.
                        w_state_next = S_RUN;
                    end
                end

                S_DONE: begin
                    w_prescale_next = '0;
                    if (load) begin
                        w_count_next  = load_val;
                        w_reload_next = load_val;
                        w_state_next  = S_IDLE;
                    end else if (start && w_reload_nonzero) begin
                        w_count_next = r_reload;
                        w_state_next = S_RUN;
                    end
                end

                default: begin
                    w_state_next    = S_IDLE;
                    w_count_next    = '0;
                    w_prescale_next = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers (falling edge, asynchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_reload     <= '0;
            r_prescale   <= '0;
            r_zero_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_reload     <= w_reload_next;
            r_prescale   <= w_prescale_next;
            r_zero_pulse <= w_zero_pulse_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registered values, or decodes of the registered state
    // -------------------------------------------------------------------------
    assign count      = r_count;
    assign state      = r_state;
    assign busy       = (r_state == S_RUN) || (r_state == S_PAUSED);
    assign done       = (r_state == S_DONE);
    assign zero_pulse = r_zero_pulse;

endmodule
